// File: rtl/nios_fprint_monmem_arbiter_if.sv
// Avalon-MM requester port bundle used between one requester and the
// monitor-memory arbiter.
//   address/byteenable/read/write/writedata : requester -> arbiter command
//   waitrequest                             : arbiter -> requester stall
//   readdata/readdatavalid                  : arbiter -> requester read return
// The master modport is the requester side; the slave modport is the arbiter side.
interface nios_fprint_monmem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios_fprint_monmem_arbiter.sv
// Two-requester arbiter in front of the monitor core's single-port on-chip RAM.
// At most one command is granted per cycle; the losing requester is stalled
// with waitrequest. Read data returns one cycle after accept, tagged to the
// port that issued the read.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   p0, p1            : Avalon-MM requester ports (slave modport)
//   ram_address       : RAM word address
//   ram_byteenable    : RAM byte lanes (all lanes on reads)
//   ram_chipselect    : RAM access strobe
//   ram_write         : RAM write strobe
//   ram_writedata     : RAM write data
//   ram_clken         : RAM clock enable, tied high
//   ram_readdata      : RAM output, valid the cycle after the address
module nios_fprint_monmem_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_fprint_monmem_arbiter_if.slave p0,
  nios_fprint_monmem_arbiter_if.slave p1,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL = {BE_W{1'b1}};

  logic       req0_s;
  logic       req1_s;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       last_grant_r;   // 0 = port 0 granted last, 1 = port 1
  logic [1:0] rd_pend_r;      // one-hot at most: read in flight per port

  // Request decode and grant selection.
  always_comb begin
    req0_s = p0.read | p0.write;
    req1_s = p1.read | p1.write;
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!reset_n) begin
      // Nothing is accepted while in reset; requesters see waitrequest.
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_s && req1_s) begin
      if (FIXED_PRIO != 0) begin
        gnt0_s = 1'b1;
      end else if (last_grant_r) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else begin
      gnt0_s = req0_s;
      gnt1_s = req1_s;
    end
  end

  // Command mux onto the RAM port and per-port handshake outputs.
  always_comb begin
    p0.waitrequest   = req0_s & ~gnt0_s;
    p1.waitrequest   = req1_s & ~gnt1_s;
    p0.readdata      = ram_readdata;
    p1.readdata      = ram_readdata;
    p0.readdatavalid = rd_pend_r[0];
    p1.readdatavalid = rd_pend_r[1];
    ram_clken        = 1'b1;
    ram_chipselect   = gnt0_s | gnt1_s;
    ram_write        = (gnt0_s & p0.write) | (gnt1_s & p1.write);
    if (gnt1_s) begin
      ram_address    = p1.address;
      ram_writedata  = p1.writedata;
      ram_byteenable = p1.write ? p1.byteenable : BE_ALL;
    end else begin
      // Port 0 also drives the don't-care address/data when nothing is granted.
      ram_address    = p0.address;
      ram_writedata  = p0.writedata;
      ram_byteenable = p0.write ? p0.byteenable : BE_ALL;
    end
  end

  // Read-return tags and round-robin history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_r    <= 2'b00;
      last_grant_r <= 1'b1;
    end else begin
      // A granted command with write high is a write even if read is also high.
      rd_pend_r <= {gnt1_s & ~p1.write, gnt0_s & ~p0.write};
      if (gnt0_s) begin
        last_grant_r <= 1'b0;
      end else if (gnt1_s) begin
        last_grant_r <= 1'b1;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

endmodule
